// File: rtl/alu_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_sched
// Purpose  : Round-robin scheduler sharing one combinational ALU between two
//            requesters. Latches the winner's opcode/operands into registers
//            that drive the ALU, captures the ALU result one cycle later and
//            returns it with a one-cycle done pulse to the granted requester.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            i_req*/i_op*/i_a*/i_b* - per-requester request, opcode, operands
//            o_ack*              - request accepted (1-cycle pulse)
//            o_done*             - result valid (1-cycle pulse)
//            o_res               - registered result, held until next capture
//            o_busy              - high while an operation is executing
//            o_alu_op/a/b        - registered ALU inputs
//            i_alu_y             - combinational ALU result
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_sched #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req0,
  input  logic [OPW-1:0]   i_op0,
  input  logic [WIDTH-1:0] i_a0,
  input  logic [WIDTH-1:0] i_b0,
  input  logic             i_req1,
  input  logic [OPW-1:0]   i_op1,
  input  logic [WIDTH-1:0] i_a1,
  input  logic [WIDTH-1:0] i_b1,
  output logic             o_ack0,
  output logic             o_ack1,
  output logic             o_done0,
  output logic             o_done1,
  output logic [WIDTH-1:0] o_res,
  output logic             o_busy,
  output logic [OPW-1:0]   o_alu_op,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  input  logic [WIDTH-1:0] i_alu_y
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_last_gnt;
  logic             r_ack0, r_ack1, r_done0, r_done1, r_busy;
  logic [WIDTH-1:0] r_res;
  logic [OPW-1:0]   r_alu_op;
  logic [WIDTH-1:0] r_alu_a, r_alu_b;

  state_t           w_state_nxt;
  logic             w_last_gnt_nxt;
  logic             w_ack0_nxt, w_ack1_nxt, w_done0_nxt, w_done1_nxt, w_busy_nxt;
  logic [WIDTH-1:0] w_res_nxt;
  logic [OPW-1:0]   w_alu_op_nxt;
  logic [WIDTH-1:0] w_alu_a_nxt, w_alu_b_nxt;

  // Requester 0 wins when alone, or when both request and requester 1 was
  // granted last. Requester 1 wins whenever requester 0 does not.
  logic w_gnt0, w_gnt1;
  assign w_gnt0 = i_req0 & (~i_req1 | r_last_gnt);
  assign w_gnt1 = i_req1 & ~w_gnt0;

  always_comb begin
    w_state_nxt    = r_state;
    w_last_gnt_nxt = r_last_gnt;
    w_ack0_nxt     = 1'b0;
    w_ack1_nxt     = 1'b0;
    w_done0_nxt    = 1'b0;
    w_done1_nxt    = 1'b0;
    w_busy_nxt     = 1'b0;
    w_res_nxt      = r_res;
    w_alu_op_nxt   = r_alu_op;
    w_alu_a_nxt    = r_alu_a;
    w_alu_b_nxt    = r_alu_b;
    case (r_state)
      S_IDLE: begin
        if (w_gnt0 | w_gnt1) begin
          w_state_nxt    = S_EXEC;
          w_busy_nxt     = 1'b1;
          w_last_gnt_nxt = w_gnt1;
          w_ack0_nxt     = w_gnt0;
          w_ack1_nxt     = w_gnt1;
          w_alu_op_nxt   = w_gnt1 ? i_op1 : i_op0;
          w_alu_a_nxt    = w_gnt1 ? i_a1  : i_a0;
          w_alu_b_nxt    = w_gnt1 ? i_b1  : i_b0;
        end
      end
      S_EXEC: begin
        // ALU inputs have been stable for a full cycle; capture the result.
        // Requests are not looked at here, so done and the next ack can
        // never coincide.
        w_state_nxt = S_IDLE;
        w_res_nxt   = i_alu_y;
        w_done0_nxt = ~r_last_gnt;
        w_done1_nxt = r_last_gnt;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last_gnt <= 1'b1;  // requester 0 gets the first contended grant
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_busy     <= 1'b0;
      r_res      <= '0;
      r_alu_op   <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_gnt <= w_last_gnt_nxt;
      r_ack0     <= w_ack0_nxt;
      r_ack1     <= w_ack1_nxt;
      r_done0    <= w_done0_nxt;
      r_done1    <= w_done1_nxt;
      r_busy     <= w_busy_nxt;
      r_res      <= w_res_nxt;
      r_alu_op   <= w_alu_op_nxt;
      r_alu_a    <= w_alu_a_nxt;
      r_alu_b    <= w_alu_b_nxt;
    end
  end

  assign o_ack0   = r_ack0;
  assign o_ack1   = r_ack1;
  assign o_done0  = r_done0;
  assign o_done1  = r_done1;
  assign o_busy   = r_busy;
  assign o_res    = r_res;
  assign o_alu_op = r_alu_op;
  assign o_alu_a  = r_alu_a;
  assign o_alu_b  = r_alu_b;

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rr_sched
// Purpose  : Self-checking bench for alu_rr_sched with an a+b ALU stub.
//            Table of single-requester operations plus hand-written sequences
//            for contention, fairness and mid-operation reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rr_sched;

  localparam int WIDTH = 8;
  localparam int OPW   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [OPW-1:0]   op0, op1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             ack0, ack1, done0, done1, busy;
  logic [WIDTH-1:0] res, alu_a, alu_b, alu_y;
  logic [OPW-1:0]   alu_op;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // ALU stub: y = a + b, truncated to WIDTH.
  assign alu_y = alu_a + alu_b;

  alu_rr_sched #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .i_req0(req0), .i_op0(op0), .i_a0(a0), .i_b0(b0),
    .i_req1(req1), .i_op1(op1), .i_a1(a1), .i_b1(b1),
    .o_ack0(ack0), .o_ack1(ack1), .o_done0(done0), .o_done1(done1),
    .o_res(res), .o_busy(busy),
    .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .i_alu_y(alu_y)
  );

  typedef struct {
    logic             who;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_res;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {ack0,ack1,done0,done1,busy}
  function automatic logic [4:0] flags();
    return {ack0, ack1, done0, done1, busy};
  endfunction

  // One complete single-requester operation starting in an IDLE cycle.
  task automatic run_op(input vec_t v);
    if (v.who == 1'b0) begin
      req0 = 1'b1; op0 = v.op; a0 = v.a; b0 = v.b;
    end else begin
      req1 = 1'b1; op1 = v.op; a1 = v.a; b1 = v.b;
    end
    step();
    check("op_ack_flags", {27'd0, flags()}, v.who ? 32'b01001 : 32'b10001);
    check("op_alu_in", {13'd0, alu_op, alu_a, alu_b}, {13'd0, v.op, v.a, v.b});
    // Drop the request and scramble the inputs: the result must come from
    // the latched operands.
    req0 = 1'b0; req1 = 1'b0;
    op0 = ~v.op; a0 = ~v.a; b0 = 8'h5A;
    op1 = ~v.op; a1 = ~v.a; b1 = 8'hA5;
    step();
    check("op_done_flags", {27'd0, flags()}, v.who ? 32'b00010 : 32'b00100);
    check("op_res", {24'd0, res}, {24'd0, v.exp_res});
  endtask

  initial begin
    vecs[0] = '{1'b0, 3'h0, 8'h12, 8'h34, 8'h46};
    vecs[1] = '{1'b0, 3'h1, 8'hFF, 8'h02, 8'h01};  // overflow passthrough
    vecs[2] = '{1'b1, 3'h2, 8'h10, 8'h20, 8'h30};
    vecs[3] = '{1'b1, 3'h3, 8'h80, 8'h80, 8'h00};  // repeated req1 only
    vecs[4] = '{1'b1, 3'h5, 8'h01, 8'hFE, 8'hFF};
    vecs[5] = '{1'b0, 3'h7, 8'hAA, 8'h55, 8'hFF};

    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    op0 = '0; a0 = '0; b0 = '0; op1 = '0; a1 = '0; b1 = '0;
    step(); step();
    check("reset_flags", {27'd0, flags()}, 32'd0);
    check("reset_regs", {24'd0, res}, 32'd0);
    check("reset_alu", {13'd0, alu_op, alu_a, alu_b}, 32'd0);
    rst = 1'b0;
    step();
    check("idle_no_req", {27'd0, flags()}, 32'd0);

    // Table-driven single-requester operations.
    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    // Contention from reset: both requesters hold requests continuously.
    rst = 1'b1;
    step();
    req0 = 1'b1; op0 = 3'h0; a0 = 8'h01; b0 = 8'h01;
    req1 = 1'b1; op1 = 3'h4; a1 = 8'hF0; b1 = 8'h0F;
    step();  // reset edge with requests already high
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      case (k % 4)
        0: check("rr_ack0", {27'd0, flags()}, 32'b10001);
        1: begin
          check("rr_done0", {27'd0, flags()}, 32'b00100);
          check("rr_res0", {24'd0, res}, 32'h02);
        end
        2: check("rr_ack1", {27'd0, flags()}, 32'b01001);
        default: begin
          check("rr_done1", {27'd0, flags()}, 32'b00010);
          check("rr_res1", {24'd0, res}, 32'hFF);
        end
      endcase
    end
    req0 = 1'b0; req1 = 1'b0;
    step();

    // Reset during EXEC: grant 0 first so a lost priority reset would show up
    // as the next contended grant going to requester 1.
    req0 = 1'b1; a0 = 8'h05; b0 = 8'h06;
    step();
    check("mid_ack0", {27'd0, flags()}, 32'b10001);
    req0 = 1'b0;
    rst = 1'b1;
    step();
    check("mid_rst_flags", {27'd0, flags()}, 32'd0);
    check("mid_rst_res", {24'd0, res}, 32'd0);
    rst = 1'b0;
    req0 = 1'b1; a0 = 8'h21; b0 = 8'h03;
    req1 = 1'b1; a1 = 8'h44; b1 = 8'h44;
    step();
    check("post_rst_ack0", {27'd0, flags()}, 32'b10001);
    req0 = 1'b0;
    step();
    check("post_rst_done0", {27'd0, flags()}, 32'b00100);
    check("post_rst_res", {24'd0, res}, 32'h24);
    step();
    check("post_rst_ack1", {27'd0, flags()}, 32'b01001);
    req1 = 1'b0;
    step();
    check("post_rst_res1", {24'd0, res}, 32'h88);
    step();
    check("final_idle", {27'd0, flags()}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Round-robin scheduler that shares one combinational 8-bit ALU between two requesters.
- Arbitrates requests and latches the winner's opcode and operands into registers that drive the ALU.
- Captures the ALU result one cycle later and returns it with a one-cycle done pulse to the granted requester.
- Sits between client blocks and the ALU instance; the ALU stays purely combinational.

Parameters:
WIDTH, 8, operand/result width in bits
OPW, 3, opcode width in bits

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous active-high reset, sampled on rising edge of clk
req0  input  1  requester 0 request valid
op0  input  OPW  requester 0 opcode
a0  input  WIDTH  requester 0 operand a
b0  input  WIDTH  requester 0 operand b
req1  input  1  requester 1 request valid
op1  input  OPW  requester 1 opcode
a1  input  WIDTH  requester 1 operand a
b1  input  WIDTH  requester 1 operand b
ack0  output  1  requester 0 accepted (1-cycle pulse)
ack1  output  1  requester 1 accepted (1-cycle pulse)
done0  output  1  result valid for requester 0 (1-cycle pulse)
done1  output  1  result valid for requester 1 (1-cycle pulse)
res  output  WIDTH  registered result, held until next capture
busy  output  1  high while state is EXEC
alu_op  output  OPW  registered opcode to ALU
alu_a  output  WIDTH  registered operand a to ALU
alu_b  output  WIDTH  registered operand b to ALU
alu_y  input  WIDTH  ALU combinational result

Behaviour:
- All outputs are registered. On rst=1 at a clock edge:
  - ack*, done*, busy, res, alu_op, alu_a, alu_b <= 0.
  - state <= IDLE; last_gnt <= 1, so requester 0 has priority first.
- FSM states: IDLE, EXEC.
- IDLE, edge with any req high:
  - Select winner. Single request wins outright. Both high: winner = requester != last_gnt.
  - Load alu_op/alu_a/alu_b from the winner's op/a/b; last_gnt <= winner.
  - Pulse ack_winner for the next cycle; busy <= 1; state <= EXEC.
- IDLE with no req: all pulses 0, ALU registers hold their values.
- EXEC, next edge:
  - res <= alu_y; done_winner <= 1 for one cycle; busy <= 0; state <= IDLE.
  - Requests are ignored in EXEC; no ack is issued.
- Latency: req high in cycle N (IDLE) -> ack in N+1 -> done and res valid in N+2.
- Throughput: one operation per 2 cycles. done of op k and ack of op k+1 never share a cycle.
- Requester protocol:
  - Hold req/op/a/b stable until ack is seen; deassert req in the cycle after ack unless issuing a new op.
  - A req still high when the FSM returns to IDLE is treated as a new request.
- Fairness: with both requesting continuously, grants alternate 0,1,0,1 (first grant to 0 after reset).
- Width: res is exactly alu_y; no extension or truncation inside the block.
- Mutual exclusion: ack0 and ack1 never high together; same for done0 and done1.
- Reset mid-operation (rst during EXEC): the operation is cancelled, no done pulse, res=0, priority returns to requester 0.
- rst takes precedence over every other event on the same edge.

Test Plan:
- ALU stub y=a+b. Reset, then req0=1, op0=3'h0, a0=8'h12, b0=8'h34 for one cycle -> ack0 next cycle with alu_a=12, alu_b=34; done0 the following cycle with res=8'h46; busy high only in the ack cycle.
- req0 and req1 held high from reset (a0=1,b0=1; a1=8'hF0,b1=8'h0F) -> ack0, done0(res=02), ack1, done1(res=FF), ack0 ... alternating every 2 cycles; never a simultaneous ack.
- Only req1 asserted repeatedly -> every grant goes to 1 without waiting for requester 0; done1 res correct each time.
- Overflow passthrough: a0=8'hFF, b0=8'h02 with stub a+b -> res=8'h01 (ALU result passed unchanged).
- rst=1 on the edge where state is EXEC -> no done pulse; res=0, busy=0; next dual request grants requester 0.
- Change op0/a0 in the cycle after ack0 -> res reflects the latched values, not the new inputs.
